// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter: round-robin, burst-locking arbiter of three pixel writers onto one framebuffer port
//   clk, rst (async, active-high)
//   req_valid/req_last[2:0], req_x/req_y[23:0] (8b per requester), req_colour[8:0] (3b per requester)
//   req_ready[2:0] (combinational grant), plot/x/y/colour (registered write port)
//   busy (burst locked), owner (locked or last-granted requester), clip_drop (clipped beat pulse)
//   Optional off-screen clipping when PIXEL_ARB_CLIP_EN is defined.
module pixel_write_arbiter #(
  parameter int H_RES = 160,
  parameter int V_RES = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [2:0]  req_last,
  input  logic [23:0] req_x,
  input  logic [23:0] req_y,
  input  logic [8:0]  req_colour,
  output logic [2:0]  req_ready,
  output logic        plot,
  output logic [7:0]  x,
  output logic [7:0]  y,
  output logic [2:0]  colour,
  output logic        busy,
  output logic [1:0]  owner,
  output logic        clip_drop
);
`ifdef PIXEL_ARB_CLIP_EN
  localparam logic CLIP_EN = 1'b1;
`else
  localparam logic CLIP_EN = 1'b0;
`endif
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state;
  logic [1:0] rr_ptr, winner, g;
  logic [7:0] gx, gy;
  logic [2:0] gc;
  logic gl, xfer, clip;
  function automatic logic [1:0] inc3(input logic [1:0] p);
    return p == 2'd2 ? 2'd0 : p + 2'd1;
  endfunction
  always_comb begin
    winner = req_valid[rr_ptr] ? rr_ptr : req_valid[inc3(rr_ptr)] ? inc3(rr_ptr) : inc3(inc3(rr_ptr));
    g = state == LOCK ? owner : winner;
    req_ready = rst ? 3'b000 : (state == LOCK || |req_valid) ? 3'b001 << g : 3'b000;
    xfer = |(req_valid & req_ready);
    gl = req_last[g];
    gx = req_x[8*g +: 8];
    gy = req_y[8*g +: 8];
    gc = req_colour[3*g +: 3];
    clip = CLIP_EN & (32'(gx) >= H_RES || 32'(gy) >= V_RES);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rr_ptr <= 2'd0;
      owner <= 2'd0;
      busy <= 1'b0;
      plot <= 1'b0;
      clip_drop <= 1'b0;
      x <= 8'd0;
      y <= 8'd0;
      colour <= 3'd0;
    end else begin
      plot <= xfer & ~clip;
      clip_drop <= xfer & clip;
      if (xfer) begin
        x <= gx;
        y <= gy;
        colour <= gc;
        owner <= g;
        state <= gl ? IDLE : LOCK;
        busy <= ~gl;
        if (gl) rr_ptr <= inc3(g);
      end
    end
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// tb_pixel_write_arbiter: scoreboard bench with a behavioural arbitration model
module tb_pixel_write_arbiter;
  logic clk = 0, rst = 1;
  logic [2:0] req_valid = 0, req_last = 0;
  logic [23:0] req_x = 0, req_y = 0;
  logic [8:0] req_colour = 0;
  logic [2:0] req_ready;
  logic plot, busy, clip_drop;
  logic [7:0] x, y;
  logic [2:0] colour;
  logic [1:0] owner;
`ifdef PIXEL_ARB_CLIP_EN
  localparam bit CLIP = 1;
`else
  localparam bit CLIP = 0;
`endif
  pixel_write_arbiter dut (.clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_ready(req_ready), .plot(plot),
    .x(x), .y(y), .colour(colour), .busy(busy), .owner(owner), .clip_drop(clip_drop));
  always #5 clk = ~clk;
  typedef struct {logic p, c, b; logic [1:0] o; logic [7:0] x, y; logic [2:0] col;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int lock_owner = -1, rr = 0;
  logic [1:0] m_owner = 0;
  logic [7:0] mx = 0, my = 0;
  logic [2:0] mc = 0;
  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  function automatic void mreset();
    lock_owner = -1; rr = 0; m_owner = 0; mx = 0; my = 0; mc = 0;
  endfunction
  function automatic exp_t snap(input logic p, input logic c);
    exp_t e;
    e.p = p; e.c = c; e.b = lock_owner >= 0; e.o = m_owner; e.x = mx; e.y = my; e.col = mc;
    return e;
  endfunction
  task automatic cycle(input logic r, input logic [2:0] v, input logic [2:0] l,
                       input logic [23:0] xs, input logic [23:0] ys, input logic [8:0] cs);
    int g = -1;
    logic [2:0] er = 0;
    logic xf = 0, clp = 0;
    @(negedge clk);
    rst = r; req_valid = v; req_last = l; req_x = xs; req_y = ys; req_colour = cs;
    #1;
    if (r) mreset();
    else begin
      if (lock_owner >= 0) g = lock_owner;
      else for (int k = 0; k < 3; k++) if (g < 0 && v[(rr + k) % 3]) g = (rr + k) % 3;
      er = g >= 0 ? 3'(1 << g) : 3'd0;
      xf = g >= 0 ? v[g] : 1'b0;
    end
    chk("req_ready", req_ready, er);
    if (xf) begin
      clp = CLIP && (xs[8*g +: 8] >= 160 || ys[8*g +: 8] >= 120);
      m_owner = 2'(g); mx = xs[8*g +: 8]; my = ys[8*g +: 8]; mc = cs[3*g +: 3];
      if (l[g]) begin lock_owner = -1; rr = (g + 1) % 3; end
      else lock_owner = g;
    end
    q.push_back(snap(xf && !clp, xf && clp));
  endtask
  task automatic async_reset();
    #2 rst = 1;
    q.delete();
    mreset();
    q.push_back(snap(0, 0));
    #1;
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_ready", req_ready, 0);
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("plot", plot, e.p);
      chk("clip_drop", clip_drop, e.c);
      chk("busy", busy, e.b);
      chk("owner", owner, e.o);
      chk("x", x, e.x);
      chk("y", y, e.y);
      chk("colour", colour, e.col);
    end
  end
  initial begin
    req_valid = 3'b111;
    #1;
    chk("init_plot", plot, 0);
    chk("init_busy", busy, 0);
    chk("init_xy", {x, y, colour}, 0);
    chk("init_ready", req_ready, 0);
    cycle(1, 3'b111, 0, 0, 0, 0);
    cycle(1, 3'b111, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      cycle(0, 3'b010, i == 3 ? 3'b010 : 3'b000, {3{8'd10}}, {3{8'(52 + i)}}, {3{3'b100}});
    cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 3'b111, 3'b111, $urandom, $urandom, 9'($urandom));
    cycle(0, 3'b001, 0, {3{8'd1}}, {3{8'd2}}, {3{3'd1}});
    cycle(0, 3'b101, 0, {3{8'd3}}, {3{8'd4}}, {3{3'd2}});
    for (int i = 0; i < 3; i++) cycle(0, 3'b100, 3'b100, {3{8'd5}}, {3{8'd6}}, {3{3'd3}});
    cycle(0, 3'b101, 0, {3{8'd7}}, {3{8'd8}}, {3{3'd4}});
    cycle(0, 3'b101, 3'b001, {3{8'd9}}, {3{8'd10}}, {3{3'd5}});
    cycle(0, 3'b100, 3'b100, {3{8'd11}}, {3{8'd12}}, {3{3'd6}});
    cycle(0, 3'b010, 0, {3{8'd20}}, {3{8'd21}}, {3{3'd7}});
    cycle(0, 3'b010, 0, {3{8'd22}}, {3{8'd23}}, {3{3'd7}});
    async_reset();
    cycle(1, 3'b110, 0, 0, 0, 0);
    cycle(1, 3'b110, 0, 0, 0, 0);
    cycle(0, 3'b110, 3'b110, {3{8'd30}}, {3{8'd31}}, {3{3'd2}});
    cycle(0, 3'b110, 3'b110, {3{8'd32}}, {3{8'd33}}, {3{3'd3}});
    cycle(0, 3'b001, 3'b001, {3{8'd160}}, {3{8'd10}}, {3{3'd5}});
    cycle(0, 3'b001, 3'b001, {3{8'd159}}, {3{8'd119}}, {3{3'd6}});
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 59) == 0, 3'($urandom), 3'($urandom) & 3'($urandom),
            24'($urandom), 24'($urandom), 9'($urandom));
    cycle(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
